rd_fifo_pixel_unpack: RTL and testbench
=======================================

RD_FIFO_PIXEL_UNPACK -- requirements
Module: rd_fifo_pixel_unpack

Interface
REQ-001 The block SHALL have parameter IN_W, default 32, meaning the read-FIFO word width in bits.
REQ-002 The block SHALL have parameter PIX_W, default 16, meaning the pixel width in bits (RGB565); R = IN_W/PIX_W SHALL be an integer >= 1.
REQ-003 The block SHALL have parameter H_ACTIVE, default 1280, meaning active pixels per line; H_ACTIVE*PIX_W SHALL be a multiple of IN_W.
REQ-004 The block SHALL have port rd_clk, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port rd_rst, input, 1, reset, synchronous, active-high.
REQ-006 The block SHALL have port fifo_rd_data, input, IN_W, the word from the prefetch FIFO, valid while fifo_rd_vld=1.
REQ-007 The block SHALL have port fifo_rd_vld, input, 1, the prefetch FIFO word-available flag.
REQ-008 The block SHALL have port fifo_rd_en, output, 1, the pop strobe; a word transfers when fifo_rd_vld & fifo_rd_en.
REQ-009 The block SHALL have port frame_sync, input, 1, a frame-start pulse from video timing.
REQ-010 The block SHALL have port pix_req, input, 1, the timing generator demanding one active pixel this cycle.
REQ-011 The block SHALL have port pix_data, output, PIX_W, the unpacked pixel.
REQ-012 The block SHALL have port pix_vld, output, 1, qualifying pix_data.
REQ-013 The block SHALL have port line_end, output, 1, a pulse with the last pixel slot of a line.
REQ-014 The block SHALL have port underflow, output, 1, a pulse when a pixel was demanded but no word was held.
REQ-015 The block SHALL have port underflow_cnt, output, 16, the saturating underflow count.

Function
REQ-016 The state machine SHALL have states IDLE and RUN; it SHALL go IDLE->RUN on frame_sync, and frame_sync in RUN SHALL restart the frame while staying in RUN.
REQ-017 On frame_sync the block SHALL clear sub_idx and pix_cnt and discard any held word (word_vld<=0).
REQ-018 Holding register word_q/word_vld SHALL hold one FIFO word; a pop loads it on the next edge.
REQ-019 consume = RUN & pix_req & word_vld & ~frame_sync.
REQ-020 fifo_rd_en SHALL equal fifo_rd_vld & RUN & ~frame_sync & (~word_vld | (consume & sub_idx==R-1)) and SHALL be combinational.
REQ-021 Pixels SHALL be emitted LSB-first: slice k = word_q[k*PIX_W +: PIX_W], k = sub_idx.
REQ-022 On consume, sub_idx SHALL increment modulo R; at R-1 word_vld SHALL clear, unless a simultaneous pop reloads it.
REQ-023 pix_data/pix_vld SHALL be registered with a latency of 1 cycle from the pix_req edge; pix_vld<=consume, and pix_data SHALL hold its value when pix_vld=0.
REQ-024 underflow SHALL pulse (registered, 1 cycle latency) on RUN & pix_req & ~word_vld & ~frame_sync; the slot is lost, and sub_idx and word_vld stay unchanged.
REQ-025 pix_cnt SHALL increment on every RUN pix_req (consumed or underflow), wrapping at H_ACTIVE-1 to 0.
REQ-026 line_end SHALL be registered alongside pix_vld for the pix_cnt==H_ACTIVE-1 slot.
REQ-027 In IDLE, pix_req SHALL be ignored: no pop, no pix_vld, no underflow, no count.

Reset
REQ-028 On rd_rst=1 at a rd_clk edge the block SHALL enter IDLE with word_vld=0, sub_idx=0, pix_cnt=0, pix_vld=0, pix_data=0, line_end=0, underflow=0, underflow_cnt=0.
REQ-029 fifo_rd_en SHALL be 0 while rd_rst=1.
REQ-030 Reset mid-line SHALL discard the held word; the words already in the FIFO are not flushed by this block.

Configuration
REQ-031 With UNPACK_UNDERFLOW_CNT_EN defined, underflow_cnt SHALL increment on each underflow pulse, saturate at 16'hFFFF, and clear only on rd_rst.
REQ-032 Without UNPACK_UNDERFLOW_CNT_EN, underflow_cnt SHALL be tied to 0 and no counter SHALL be built.

Verification
REQ-033 Reset, frame_sync, fifo_rd_vld=1 with word 32'hBBBB_AAAA, pix_req held high -> pix_vld with pix_data 16'hAAAA then 16'hBBBB; fifo_rd_en is 1 once per 2 pix_req.
REQ-034 fifo_rd_vld=0, pix_req=1 in RUN -> underflow pulses every cycle, pix_vld=0, underflow_cnt increments (macro on) or stays 0 (macro off).
REQ-035 Set H_ACTIVE=8 and stream 4 words -> line_end=1 coincident with the 8th pix_vld, and pix_cnt wraps to 0.
REQ-036 frame_sync after 1 pixel of word 32'h2222_1111 -> next pixels come from the next FIFO word's low half; 16'h2222 is never output.
REQ-037 Assert rd_rst mid-line while word_vld=1 -> all outputs are 0 the next cycle, the state is IDLE, and pix_req is ignored until frame_sync.
REQ-038 Drive pix_req for 70000 cycles with an empty FIFO (macro on) -> underflow_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/rd_fifo_pixel_unpack.sv
// Read-side pixel unpacker: pops words from a prefetch FIFO and emits one pixel per pix_req, LSB slice first.
// Optional saturating underflow counter is built only when UNPACK_UNDERFLOW_CNT_EN is defined.
module rd_fifo_pixel_unpack #(
    parameter int IN_W     = 32,
    parameter int PIX_W    = 16,
    parameter int H_ACTIVE = 1280
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic [IN_W-1:0]  fifo_rd_data,
    input  logic             fifo_rd_vld,
    output logic             fifo_rd_en,
    input  logic             frame_sync,
    input  logic             pix_req,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_vld,
    output logic             line_end,
    output logic             underflow,
    output logic [15:0]      underflow_cnt
);

    localparam int R     = IN_W / PIX_W;
    localparam int SUB_W = (R > 1) ? $clog2(R) : 1;
    localparam int CNT_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(R - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H_ACTIVE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q;
    logic [IN_W-1:0]    word_q;
    logic               wordVld_q, wordVld_d;
    logic [SUB_W-1:0]   subIdx_q, subIdx_d;
    logic [CNT_W-1:0]   pixCnt_q, pixCnt_d;
    logic [PIX_W-1:0]   pixData_q;
    logic               pixVld_q;
    logic               lineEnd_q;
    logic               underflow_q;

    logic               run;
    logic               slot;
    logic               consume;
    logic               starve;
    logic               lastSlice;
    logic               lastPix;
    logic               pop;
    logic [PIX_W-1:0]   slice [R];
    logic [PIX_W-1:0]   curPix;

    // A slot is any pixel demand while running; frame_sync steals that cycle for the restart.
    assign run       = (state_q == RUN);
    assign slot      = run & pix_req & ~frame_sync;
    assign consume   = slot & wordVld_q;
    assign starve    = slot & ~wordVld_q;
    assign lastSlice = (subIdx_q == SUB_LAST);
    assign lastPix   = (pixCnt_q == CNT_LAST);

    // Refill when empty, or in the same cycle the last slice of the held word is consumed.
    assign pop = ~rd_rst & fifo_rd_vld & run & ~frame_sync
               & (~wordVld_q | (consume & lastSlice));
    assign fifo_rd_en = pop;

    always_comb begin
        for (int k = 0; k < R; k++) begin
            slice[k] = word_q[k*PIX_W +: PIX_W];
        end
    end

    assign curPix = slice[subIdx_q];

    always_comb begin
        subIdx_d  = subIdx_q;
        wordVld_d = wordVld_q;
        pixCnt_d  = pixCnt_q;
        if (frame_sync) begin
            subIdx_d  = '0;
            wordVld_d = 1'b0;
            pixCnt_d  = '0;
        end else begin
            if (consume) begin
                subIdx_d = lastSlice ? '0 : subIdx_q + SUB_W'(1);
                if (lastSlice) begin
                    wordVld_d = 1'b0;
                end
            end
            if (pop) begin
                wordVld_d = 1'b1;
            end
            if (slot) begin
                pixCnt_d = lastPix ? '0 : pixCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            wordVld_q   <= 1'b0;
            subIdx_q    <= '0;
            pixCnt_q    <= '0;
            pixData_q   <= '0;
            pixVld_q    <= 1'b0;
            lineEnd_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (frame_sync) begin
                state_q <= RUN;
            end
            if (pop) begin
                word_q <= fifo_rd_data;
            end
            wordVld_q <= wordVld_d;
            subIdx_q  <= subIdx_d;
            pixCnt_q  <= pixCnt_d;
            pixVld_q  <= consume;
            if (consume) begin
                pixData_q <= curPix;
            end
            lineEnd_q   <= slot & lastPix;
            underflow_q <= starve;
        end
    end

    assign pix_data  = pixData_q;
    assign pix_vld   = pixVld_q;
    assign line_end  = lineEnd_q;
    assign underflow = underflow_q;

`ifdef UNPACK_UNDERFLOW_CNT_EN
    logic [15:0] ufCnt_q, ufCnt_d;

    // Counts in step with the underflow pulse and sticks at all-ones until reset.
    always_comb begin
        ufCnt_d = ufCnt_q;
        if (starve && (ufCnt_q != 16'hFFFF)) begin
            ufCnt_d = ufCnt_q + 16'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            ufCnt_q <= '0;
        end else begin
            ufCnt_q <= ufCnt_d;
        end
    end

    assign underflow_cnt = ufCnt_q;
`else
    assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_rd_fifo_pixel_unpack.sv
// Self-checking bench for rd_fifo_pixel_unpack (H_ACTIVE=8): vector table with registered-output
// scoreboard, a streaming pop/pixel-order sequence, and the underflow counter saturation run.
module tb_rd_fifo_pixel_unpack;

    localparam int IN_W     = 32;
    localparam int PIX_W    = 16;
    localparam int H_ACTIVE = 8;
    localparam int NVEC     = 30;

    logic             rd_clk;
    logic             rd_rst;
    logic [IN_W-1:0]  fifo_rd_data;
    logic             fifo_rd_vld;
    logic             fifo_rd_en;
    logic             frame_sync;
    logic             pix_req;
    logic [PIX_W-1:0] pix_data;
    logic             pix_vld;
    logic             line_end;
    logic             underflow;
    logic [15:0]      underflow_cnt;

    typedef struct {
        logic        rst;
        logic        fs;
        logic        req;
        logic        vld;
        logic [31:0] data;
        logic        expEn;
        logic        expVld;
        logic [15:0] expData;
        logic        expLe;
        logic        expUf;
    } vec_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic        le;
        logic        uf;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    logic [15:0] pixSb [$];
    int          compared = 0;
    int          mismatched = 0;
    int          ufModel = 0;

    rd_fifo_pixel_unpack #(
        .IN_W    (IN_W),
        .PIX_W   (PIX_W),
        .H_ACTIVE(H_ACTIVE)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_en   (fifo_rd_en),
        .frame_sync   (frame_sync),
        .pix_req      (pix_req),
        .pix_data     (pix_data),
        .pix_vld      (pix_vld),
        .line_end     (line_end),
        .underflow    (underflow),
        .underflow_cnt(underflow_cnt)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic rst, input logic fs, input logic req, input logic vld,
                                   input logic [31:0] data, input logic expEn, input logic expVld,
                                   input logic [15:0] expData, input logic expLe, input logic expUf);
        vec_t v;
        v.rst = rst; v.fs = fs; v.req = req; v.vld = vld; v.data = data;
        v.expEn = expEn; v.expVld = expVld; v.expData = expData; v.expLe = expLe; v.expUf = expUf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one row, checks the combinational pop strobe, then checks the registered outputs after the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        logic [15:0] expCnt;
        rd_rst       = v.rst;
        frame_sync   = v.fs;
        pix_req      = v.req;
        fifo_rd_vld  = v.vld;
        fifo_rd_data = v.data;
        #1;
        checkOutput($sformatf("row%0d fifo_rd_en", idx), 32'(fifo_rd_en), 32'(v.expEn));
        e.rst = v.rst; e.vld = v.expVld; e.data = v.expData; e.le = v.expLe; e.uf = v.expUf;
        sb.push_back(e);
        @(posedge rd_clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL row%0d scoreboard: got empty queue, expected one entry", idx);
        end else begin
            got = sb.pop_front();
            if (got.rst) ufModel = 0;
            else if (got.uf && ufModel < 65535) ufModel++;
`ifdef UNPACK_UNDERFLOW_CNT_EN
            expCnt = 16'(ufModel);
`else
            expCnt = 16'h0000;
`endif
            checkOutput($sformatf("row%0d pix_vld", idx), 32'(pix_vld), 32'(got.vld));
            checkOutput($sformatf("row%0d pix_data", idx), 32'(pix_data), 32'(got.data));
            checkOutput($sformatf("row%0d line_end", idx), 32'(line_end), 32'(got.le));
            checkOutput($sformatf("row%0d underflow", idx), 32'(underflow), 32'(got.uf));
            checkOutput($sformatf("row%0d underflow_cnt", idx), 32'(underflow_cnt), 32'(expCnt));
        end
    endtask

    task automatic resetAndSync();
        rd_rst = 1'b1; frame_sync = 1'b0; pix_req = 1'b0; fifo_rd_vld = 1'b0; fifo_rd_data = '0;
        @(posedge rd_clk); #1;
        rd_rst = 1'b0; frame_sync = 1'b1;
        @(posedge rd_clk); #1;
        frame_sync = 1'b0;
    endtask

    initial begin
        int pops;
        int seen;
        int wordIdx;
        logic [15:0] expPix;

        // rst fs req vld data | en pix_vld pix_data line_end underflow
        vecs[0]  = mkVec(1, 0, 1, 1, 32'hBBBB_AAAA, 0, 0, 16'h0000, 0, 0);
        vecs[1]  = mkVec(1, 0, 1, 1, 32'hBBBB_AAAA, 0, 0, 16'h0000, 0, 0);
        vecs[2]  = mkVec(0, 0, 1, 1, 32'hBBBB_AAAA, 0, 0, 16'h0000, 0, 0);
        vecs[3]  = mkVec(0, 1, 1, 1, 32'hBBBB_AAAA, 0, 0, 16'h0000, 0, 0);
        vecs[4]  = mkVec(0, 0, 0, 1, 32'hBBBB_AAAA, 1, 0, 16'h0000, 0, 0);
        vecs[5]  = mkVec(0, 0, 1, 1, 32'h4444_3333, 0, 1, 16'hAAAA, 0, 0);
        vecs[6]  = mkVec(0, 0, 1, 1, 32'h4444_3333, 1, 1, 16'hBBBB, 0, 0);
        vecs[7]  = mkVec(0, 0, 1, 1, 32'h6666_5555, 0, 1, 16'h3333, 0, 0);
        vecs[8]  = mkVec(0, 0, 1, 1, 32'h6666_5555, 1, 1, 16'h4444, 0, 0);
        vecs[9]  = mkVec(0, 0, 1, 1, 32'h8888_7777, 0, 1, 16'h5555, 0, 0);
        vecs[10] = mkVec(0, 0, 1, 1, 32'h8888_7777, 1, 1, 16'h6666, 0, 0);
        vecs[11] = mkVec(0, 0, 1, 1, 32'hDEAD_BEEF, 0, 1, 16'h7777, 0, 0);
        vecs[12] = mkVec(0, 0, 1, 0, 32'hDEAD_BEEF, 0, 1, 16'h8888, 1, 0);
        vecs[13] = mkVec(0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 16'h8888, 0, 1);
        vecs[14] = mkVec(0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 16'h8888, 0, 1);
        vecs[15] = mkVec(0, 0, 1, 1, 32'h2222_1111, 1, 0, 16'h8888, 0, 1);
        vecs[16] = mkVec(0, 0, 1, 1, 32'hCCCC_DDDD, 0, 1, 16'h1111, 0, 0);
        vecs[17] = mkVec(0, 1, 1, 1, 32'hCCCC_DDDD, 0, 0, 16'h1111, 0, 0);
        vecs[18] = mkVec(0, 0, 0, 1, 32'hCCCC_DDDD, 1, 0, 16'h1111, 0, 0);
        vecs[19] = mkVec(0, 0, 1, 1, 32'hEEEE_FFFF, 0, 1, 16'hDDDD, 0, 0);
        vecs[20] = mkVec(0, 0, 1, 0, 32'hEEEE_FFFF, 0, 1, 16'hCCCC, 0, 0);
        vecs[21] = mkVec(0, 0, 1, 1, 32'h1234_5678, 1, 0, 16'hCCCC, 0, 1);
        vecs[22] = mkVec(0, 0, 1, 1, 32'h9ABC_DEF0, 0, 1, 16'h5678, 0, 0);
        vecs[23] = mkVec(1, 0, 1, 1, 32'h9ABC_DEF0, 0, 0, 16'h0000, 0, 0);
        vecs[24] = mkVec(0, 0, 1, 1, 32'h9ABC_DEF0, 0, 0, 16'h0000, 0, 0);
        vecs[25] = mkVec(0, 0, 1, 1, 32'h9ABC_DEF0, 0, 0, 16'h0000, 0, 0);
        vecs[26] = mkVec(0, 1, 1, 1, 32'hBEEF_CAFE, 0, 0, 16'h0000, 0, 0);
        vecs[27] = mkVec(0, 0, 1, 1, 32'hBEEF_CAFE, 1, 0, 16'h0000, 0, 1);
        vecs[28] = mkVec(0, 0, 1, 0, 32'hBEEF_CAFE, 0, 1, 16'hCAFE, 0, 0);
        vecs[29] = mkVec(0, 0, 0, 0, 32'hBEEF_CAFE, 0, 0, 16'hCAFE, 0, 0);

        rd_rst = 1'b1; frame_sync = 1'b0; pix_req = 1'b0; fifo_rd_vld = 1'b0; fifo_rd_data = '0;
        @(posedge rd_clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Streaming with pix_req held: one pop per two pixels, pixels leave in word order, low half first.
        resetAndSync();
        pops = 0; seen = 0; wordIdx = 0;
        for (int c = 0; c < 17; c++) begin
            pix_req      = 1'b1;
            fifo_rd_vld  = 1'b1;
            fifo_rd_data = {16'(2 * wordIdx + 1) | 16'h5000, 16'(2 * wordIdx) | 16'h5000};
            #1;
            if (fifo_rd_en) begin
                pops++;
                pixSb.push_back(fifo_rd_data[15:0]);
                pixSb.push_back(fifo_rd_data[31:16]);
                wordIdx++;
            end
            @(posedge rd_clk); #1;
            if (pix_vld) begin
                seen++;
                if (pixSb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL stream pix order: got %h, expected nothing pending", pix_data);
                end else begin
                    expPix = pixSb.pop_front();
                    checkOutput($sformatf("stream pix %0d", seen), 32'(pix_data), 32'(expPix));
                end
            end
        end
        pix_req = 1'b0; fifo_rd_vld = 1'b0;
        checkOutput("stream pop count", 32'(pops), 32'd9);
        checkOutput("stream pixel count", 32'(seen), 32'd16);
        pixSb.delete();

`ifdef UNPACK_UNDERFLOW_CNT_EN
        // Empty FIFO with constant demand: counter climbs one per cycle, then pins at all-ones.
        resetAndSync();
        pix_req = 1'b1; fifo_rd_vld = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge rd_clk);
        end
        #1;
        checkOutput("underflow_cnt after 100", 32'(underflow_cnt), 32'd100);
        for (int c = 100; c < 70000; c++) begin
            @(posedge rd_clk);
        end
        #1;
        checkOutput("underflow_cnt saturated", 32'(underflow_cnt), 32'h0000_FFFF);
        checkOutput("underflow pulse at saturation", 32'(underflow), 32'd1);
        checkOutput("pix_vld during starvation", 32'(pix_vld), 32'd0);
        pix_req = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
